// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the RV32I control path: opcodes, FSM states, mux selects.
package riscv_ctrl_pkg;

    localparam int unsigned OPC_W   = 7;
    localparam int unsigned STATE_W = 3;

    // RV32I base opcode groups
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    typedef enum logic [3:0] {
        CL_R      = 4'd0,
        CL_IALU   = 4'd1,
        CL_LOAD   = 4'd2,
        CL_STORE  = 4'd3,
        CL_BRANCH = 4'd4,
        CL_JAL    = 4'd5,
        CL_JALR   = 4'd6,
        CL_LUI    = 4'd7,
        CL_AUIPC  = 4'd8,
        CL_NONE   = 4'd9
    } instr_class_t;

    // Immediate generator format select
    localparam logic [2:0] IMM_I     = 3'd0;
    localparam logic [2:0] IMM_ISHMT = 3'd1;
    localparam logic [2:0] IMM_S     = 3'd2;
    localparam logic [2:0] IMM_B     = 3'd3;
    localparam logic [2:0] IMM_U     = 3'd4;
    localparam logic [2:0] IMM_J     = 3'd5;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_JALR  = 2'd2;

    // Register write-back source select
    localparam logic [1:0] WB_ALU   = 2'd0;
    localparam logic [1:0] WB_MEM   = 2'd1;
    localparam logic [1:0] WB_PC4   = 2'd2;
    localparam logic [1:0] WB_IMM   = 2'd3;

    // Trap cause
    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

endpackage

// File: rtl/instr_class_dec.sv
// Combinational opcode/funct3 classifier: instruction class, immediate format, legality.
module instr_class_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    output logic [3:0] o_class,
    output logic [2:0] o_imm_sel,
    output logic       o_legal
);

    // Map each base opcode group to its class and immediate format
    always_comb begin
        o_class   = CL_NONE;
        o_imm_sel = IMM_I;
        o_legal   = 1'b1;
        case (i_opcode)
            OPC_OP:     o_class = CL_R;
            OPC_OP_IMM: begin
                o_class   = CL_IALU;
                o_imm_sel = (i_funct3 == 3'd1 || i_funct3 == 3'd5) ? IMM_ISHMT : IMM_I;
            end
            OPC_LOAD:   o_class = CL_LOAD;
            OPC_STORE:  begin o_class = CL_STORE;  o_imm_sel = IMM_S; end
            OPC_BRANCH: begin o_class = CL_BRANCH; o_imm_sel = IMM_B; end
            OPC_JAL:    begin o_class = CL_JAL;    o_imm_sel = IMM_J; end
            OPC_JALR:   o_class = CL_JALR;
            OPC_LUI:    begin o_class = CL_LUI;    o_imm_sel = IMM_U; end
            OPC_AUIPC:  begin o_class = CL_AUIPC;  o_imm_sel = IMM_U; end
            default:    o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I core: sequences fetch/decode/exec/mem/wb,
// owns the memory handshake, memory-wait timeout and retired-instruction counter.
module multicycle_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       i_opcode,
    input  logic [2:0]       i_funct3,
    input  logic             i_br_taken,
    input  logic             i_mem_ready,
    output logic             o_mem_req,
    output logic             o_mem_we,
    output logic             o_mem_addr_sel,
    output logic             o_ir_we,
    output logic             o_pc_we,
    output logic [1:0]       o_pc_sel,
    output logic [2:0]       o_imm_sel,
    output logic             o_alu_src_b,
    output logic             o_alu_src_a,
    output logic             o_reg_we,
    output logic [1:0]       o_wb_sel,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_instret,
    output logic [2:0]       o_state
);

    localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    state_t            r_state;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0]  r_instret;
    logic              r_trap;
    logic [1:0]        r_trap_cause;

    logic [3:0]        w_class_raw;
    instr_class_t      w_class;
    logic [2:0]        w_dec_imm_sel;
    logic              w_legal;

    state_t            w_next;
    logic              w_retire;
    logic              w_trap_set;
    logic [1:0]        w_trap_cause_n;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_mem_addr_sel;
    logic              w_ir_we;
    logic              w_pc_we;
    logic [1:0]        w_pc_sel;
    logic [2:0]        w_imm_sel;
    logic              w_alu_src_b;
    logic              w_alu_src_a;
    logic              w_reg_we;
    logic [1:0]        w_wb_sel;
    logic              w_wait_clr;
    logic              w_wait_last;

    instr_class_dec u_dec (
        .i_opcode  (i_opcode),
        .i_funct3  (i_funct3),
        .o_class   (w_class_raw),
        .o_imm_sel (w_dec_imm_sel),
        .o_legal   (w_legal)
    );

    assign w_class     = instr_class_t'(w_class_raw);
    assign w_wait_last = (r_wait_cnt == WAIT_LAST);

    // Next-state and strobe generation from the current state and handshake
    always_comb begin
        w_next         = r_state;
        w_retire       = 1'b0;
        w_trap_set     = 1'b0;
        w_trap_cause_n = CAUSE_NONE;
        w_mem_req      = 1'b0;
        w_mem_we       = 1'b0;
        w_mem_addr_sel = 1'b0;
        w_ir_we        = 1'b0;
        w_pc_we        = 1'b0;
        w_pc_sel       = PC_PLUS4;
        w_imm_sel      = IMM_I;
        w_alu_src_b    = 1'b0;
        w_alu_src_a    = 1'b0;
        w_reg_we       = 1'b0;
        w_wb_sel       = WB_ALU;

        // Datapath selects follow the decoded class while an instruction is in flight
        if (r_state == S_DECODE || r_state == S_EXEC || r_state == S_MEM || r_state == S_WB) begin
            w_imm_sel   = w_dec_imm_sel;
            w_alu_src_b = (w_class != CL_R) && (w_class != CL_BRANCH);
            w_alu_src_a = (w_class == CL_AUIPC);
            case (w_class)
                CL_LOAD:         w_wb_sel = WB_MEM;
                CL_JAL, CL_JALR: w_wb_sel = WB_PC4;
                CL_LUI:          w_wb_sel = WB_IMM;
                default:         w_wb_sel = WB_ALU;
            endcase
        end

        case (r_state)
            S_IDLE: w_next = S_FETCH;
            S_FETCH: begin
                w_mem_req = 1'b1;
                if (i_mem_ready) begin
                    w_ir_we = 1'b1;
                    w_next  = S_DECODE;
                end else if (w_wait_last) begin
                    w_next         = S_TRAP;
                    w_trap_set     = 1'b1;
                    w_trap_cause_n = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                if (w_legal) begin
                    w_next = S_EXEC;
                end else begin
                    w_next         = S_TRAP;
                    w_trap_set     = 1'b1;
                    w_trap_cause_n = CAUSE_ILLEGAL;
                end
            end
            S_EXEC: begin
                case (w_class)
                    CL_BRANCH: begin
                        w_pc_we  = 1'b1;
                        w_pc_sel = i_br_taken ? PC_IMM : PC_PLUS4;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                    CL_LOAD, CL_STORE: w_next = S_MEM;
                    default:           w_next = S_WB;
                endcase
            end
            S_MEM: begin
                w_mem_req      = 1'b1;
                w_mem_addr_sel = 1'b1;
                w_mem_we       = (w_class == CL_STORE);
                if (i_mem_ready) begin
                    if (w_class == CL_STORE) begin
                        w_pc_we  = 1'b1;
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_last) begin
                    w_next         = S_TRAP;
                    w_trap_set     = 1'b1;
                    w_trap_cause_n = CAUSE_TIMEOUT;
                end
            end
            S_WB: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                w_next   = S_FETCH;
                case (w_class)
                    CL_JAL:  w_pc_sel = PC_IMM;
                    CL_JALR: w_pc_sel = PC_JALR;
                    default: w_pc_sel = PC_PLUS4;
                endcase
            end
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_IDLE;
        endcase
    end

    // Wait counter restarts whenever a new memory phase begins
    assign w_wait_clr = (w_next != r_state) && (w_next == S_FETCH || w_next == S_MEM);

    // State, wait counter, retire counter and sticky trap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_wait_cnt   <= '0;
            r_instret    <= '0;
            r_trap       <= 1'b0;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state <= w_next;
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_mem_req && !i_mem_ready) begin
                r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
            end
            if (w_retire) begin
                r_instret <= r_instret + CNT_W'(1);
            end
            if (w_trap_set) begin
                r_trap       <= 1'b1;
                r_trap_cause <= w_trap_cause_n;
            end
        end
    end

    assign o_mem_req      = w_mem_req;
    assign o_mem_we       = w_mem_we;
    assign o_mem_addr_sel = w_mem_addr_sel;
    assign o_ir_we        = w_ir_we;
    assign o_pc_we        = w_pc_we;
    assign o_pc_sel       = w_pc_sel;
    assign o_imm_sel      = w_imm_sel;
    assign o_alu_src_b    = w_alu_src_b;
    assign o_alu_src_a    = w_alu_src_a;
    assign o_reg_we       = w_reg_we;
    assign o_wb_sel       = w_wb_sel;
    assign o_trap         = r_trap;
    assign o_trap_cause   = r_trap_cause;
    assign o_instret      = r_instret;
    assign o_state        = r_state;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Main control FSM for the multi-cycle variant of the RV32I core.
- Sequences the shared datapath (PC, IR, register file, immediate generator, ALU, unified memory port) through FETCH/DECODE/EXEC/MEM/WB.
- Drives the immediate-type select to the immediate generator.
- Owns the memory request handshake, a memory-wait timeout, and the retired-instruction counter.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready before trapping (>=1)
- CNT_W, 32, width of instret counter

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0], valid from DECODE onward
- funct3  in  3  IR[14:12]
- br_taken  in  1  ALU branch-compare result, valid in EXEC
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory request strobe, held until mem_ready
- mem_we  out  1  store request, qualified by mem_req
- mem_addr_sel  out  1  0=PC, 1=ALU result
- ir_we  out  1  load IR from memory read data
- pc_we  out  1  update PC
- pc_sel  out  2  0=PC+4, 1=PC+imm, 2=(rs1+imm)&~1
- imm_sel  out  3  0=I, 1=I-shamt, 2=S, 3=B, 4=U, 5=J
- alu_src_b  out  1  0=rs2, 1=imm
- alu_src_a  out  1  0=rs1, 1=PC (AUIPC)
- reg_we  out  1  register-file write
- wb_sel  out  2  0=ALU, 1=mem data, 2=PC+4, 3=imm (LUI)
- trap  out  1  sticky fault flag
- trap_cause  out  2  0=none, 1=illegal opcode, 2=memory timeout
- instret  out  CNT_W  retired-instruction count
- state_o  out  3  current state, debug

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset (async, rst_n=0):
  - state=IDLE, wait_cnt=0, instret=0, trap=0, trap_cause=0.
  - All strobes (mem_req, mem_we, ir_we, pc_we, reg_we) are 0.
- Output timing: strobes are combinational from state, plus mem_ready where noted. Counters and state are registered.
- IDLE:
  - All strobes 0.
  - Unconditional transition to FETCH next cycle, so the first mem_req appears in the 2nd cycle after reset release.
- FETCH:
  - mem_req=1, mem_addr_sel=0, mem_we=0.
  - On mem_ready: ir_we=1 in the same cycle, then -> DECODE.
- DECODE:
  - Classify opcode into R, I-ALU, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Any other opcode, including SYSTEM (1110011), -> TRAP with cause=1.
  - Otherwise -> EXEC. No strobes.
- imm_sel:
  - Driven from DECODE through WB.
  - I-ALU with funct3 = 1 or 5 -> 1; other I-ALU, LOAD, JALR -> 0.
  - STORE -> 2; BRANCH -> 3; LUI/AUIPC -> 4; JAL -> 5.
  - R-type -> 0 (don't-care).
- alu_src_b=1 for all types except R and BRANCH. alu_src_a=1 only for AUIPC.
- EXEC:
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, instret++, -> FETCH.
  - LOAD/STORE -> MEM.
  - All others -> WB.
- MEM:
  - mem_req=1, mem_addr_sel=1, mem_we=1 for STORE.
  - On mem_ready, STORE: pc_we=1, pc_sel=0, instret++, -> FETCH.
  - On mem_ready, LOAD: -> WB.
- WB:
  - reg_we=1 and pc_we=1, one cycle, instret++, -> FETCH.
  - wb_sel: LOAD=1; JAL/JALR=2; LUI=3; others=0.
  - pc_sel: JAL=1; JALR=2; others=0.
- Timeout:
  - wait_cnt clears on entry to FETCH or MEM and increments each cycle mem_req=1 && !mem_ready.
  - When wait_cnt reaches MEM_TIMEOUT with mem_ready still low: -> TRAP, cause=2, mem_req drops next cycle.
  - mem_ready on the same cycle as the limit wins; no trap.
- TRAP:
  - trap=1, trap_cause held, all strobes 0.
  - Stays in TRAP until reset.
  - Trapped instructions do not increment instret.
- instret wraps modulo 2^CNT_W, with no saturation.
- mem_ready sampled outside FETCH/MEM is ignored.
- Reset asserted mid-request drops mem_req asynchronously.
- At most one of ir_we/pc_we/reg_we sequences per instruction; pc_we is asserted exactly once per retired instruction.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants for the RV32I base groups
  - the state encoding (IDLE=0 .. TRAP=6)
  - imm_sel, pc_sel, wb_sel and trap_cause encodings
- Shared with the immediate generator and datapath muxes.
- One sub-module: instr_class_dec, a combinational opcode/funct3 -> {class, imm_sel, legal} decoder. It is instanced here and reusable by the single-cycle core.

Test Plan:
- Reset, release, mem_ready=1 always, feed ADDI (0010011) -> IDLE 1 cycle; FETCH->DECODE->EXEC->WB; reg_we=1 once, wb_sel=0, imm_sel=0; instret=1 after 5 cycles post-reset.
- BEQ with br_taken=1, then with 0 -> EXEC pc_we=1 with pc_sel=1, then pc_sel=0; reg_we never asserted; imm_sel=3.
- LW with mem_ready delayed 3 cycles in both FETCH and MEM -> mem_req held 4 cycles each; WB wb_sel=1; then SW -> mem_we=1 in MEM, retires from MEM with no WB.
- mem_ready held low in FETCH, MEM_TIMEOUT=16 -> TRAP entered after 16 waiting cycles, trap_cause=2, mem_req=0 thereafter; with mem_ready on cycle 16 -> no trap.
- Opcode 1110011 (ECALL) -> TRAP from DECODE, trap_cause=1, instret unchanged, no pc_we.
- Assert rst_n=0 during MEM wait of a store -> mem_req/mem_we fall immediately; after release, sequence restarts at IDLE with instret=0.
